fft_bin_reader: RTL and testbench

FFT_BIN_READER -- requirements
Module: fft_bin_reader

---
 rtl/fft_bin_reader.sv | 97 +++++++++
 tb/tb_fft_bin_reader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fft_bin_reader.sv
// fft_bin_reader: streams a completed FFT result frame out of the result RAM
// as ready/valid beats of two bins, through a 2-entry fall-through FIFO.
module fft_bin_reader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     reset_fft,
    input  logic                     fft_done,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [4*DATA_W-1:0]      rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        output_index,
    output logic signed [DATA_W-1:0] real0,
    output logic signed [DATA_W-1:0] imag0,
    output logic signed [DATA_W-1:0] real1,
    output logic signed [DATA_W-1:0] imag1,
    output logic                     out_last,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overrun
);
    localparam int EW = ADDR_W + 4*DATA_W;
    localparam logic [ADDR_W-1:0] LAST = '1;
    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d, tag_q;
    logic              pend_q, overrun_q;
    logic [1:0]        occ_q, occ_d;
    logic [EW-1:0]     e0_q, e1_q, e0_d, e1_d, inc, head, nxt;
    logic              pop;

    always_ff @(posedge clk or posedge reset_fft) begin
        if (reset_fft) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tag_q     <= '0;
            pend_q    <= 1'b0;
            overrun_q <= 1'b0;
            occ_q     <= '0;
            e0_q      <= '0;
            e1_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tag_q     <= rd_addr;
            pend_q    <= rd_en;
            overrun_q <= overrun_q | (fft_done && state_q != IDLE);
            occ_q     <= occ_d;
            e0_q      <= e0_d;
            e1_q      <= e1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: if (fft_done) begin
                state_d = STREAM;
                cnt_d   = '0;
            end
            STREAM: begin
                // Reads in flight count against FIFO space so nothing can overflow.
                rd_en = (occ_q + 2'(pend_q)) < 2'd2;
                if (rd_en) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = FLUSH;
                end
            end
            FLUSH: if (pop && out_last) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Returning word falls straight through to the head when the FIFO is empty.
    assign inc       = {tag_q, rd_data};
    assign head      = occ_q == 2'd0 ? inc : e0_q;
    assign nxt       = occ_q == 2'd2 ? e1_q : inc;
    assign out_valid = occ_q != 2'd0 || pend_q;
    assign pop       = out_valid && out_ready;
    assign occ_d     = occ_q + 2'(pend_q) - 2'(pop);
    assign e0_d      = pop ? nxt : head;
    assign e1_d      = pop ? inc : nxt;

    assign rd_addr      = cnt_q;
    assign output_index = out_valid ? head[EW-1 -: ADDR_W] : '0;
    assign {real0, imag0, real1, imag1} = out_valid ? head[4*DATA_W-1:0] : '0;
    assign out_last     = out_valid && output_index == LAST;
    assign busy         = state_q != IDLE;
    assign frame_done   = state_q == DONE;
    assign overrun      = overrun_q;
endmodule

// File: tb/tb_fft_bin_reader.sv
// tb_fft_bin_reader: drives whole frames from a RAM model and checks every beat
// against a frame-level reference (bin formula, in-order index, timing).
module tb_fft_bin_reader;
    localparam int AW = 9, DW = 16, N = 1 << AW;
    typedef struct { int mode; int dup_at; bit fd_glitch; bit exp_ovr; } vec_t;

    logic clk = 0, reset_fft = 1, fft_done = 0, out_ready = 0;
    logic rd_en, out_valid, out_last, busy, frame_done, overrun;
    logic [AW-1:0] rd_addr, output_index;
    logic [4*DW-1:0] rd_data = '0;
    logic signed [DW-1:0] real0, imag0, real1, imag1;
    logic [63:0] data;

    int checks = 0, errors = 0;
    int cyc = 0, exp_idx = 0, exp_rd = 0, beats = 0, rd_cnt = 0, fd_cnt = 0, busy_cyc = 0;
    int last_cyc = 0, fd_cyc = 0, first_cyc = 0, hold_i = 0;
    bit holding = 0;
    logic [63:0] hold_d = '0;
    vec_t tbl[3];

    always #5 clk = ~clk;

    fft_bin_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset_fft(reset_fft), .fft_done(fft_done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .output_index(output_index),
        .real0(real0), .imag0(imag0), .real1(real1), .imag1(imag1),
        .out_last(out_last), .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    assign data = {real0, imag0, real1, imag1};

    function automatic logic [63:0] word(input int k);
        logic signed [DW-1:0] a, b;
        a = DW'(k);
        b = DW'(k + 1);
        return {a, -a, b, -b};
    endfunction

    always @(posedge clk) if (rd_en) rd_data <= word(int'(rd_addr));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (reset_fft) begin
            exp_idx = 0;
            exp_rd = 0;
            holding = 0;
        end else begin
            if (busy) busy_cyc++;
            if (rd_en) begin
                chk("rd_addr", longint'(rd_addr), exp_rd);
                chk("outstanding_le_2", longint'(exp_rd + 1 - exp_idx <= 2), 1);
                exp_rd++;
                rd_cnt++;
            end
            if (holding) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", data, hold_d);
                chk("stall_index", longint'(output_index), hold_i);
            end
            holding = out_valid && !out_ready;
            hold_d = data;
            hold_i = int'(output_index);
            if (out_valid && out_ready) begin
                chk("beat_index", longint'(output_index), exp_idx);
                chk("beat_data", data, word(exp_idx));
                chk("beat_last", out_last, longint'(exp_idx == N - 1));
                if (exp_idx == 0) first_cyc = cyc;
                if (exp_idx == N - 1) last_cyc = cyc;
                exp_idx++;
                beats++;
            end
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = cyc;
                exp_idx = 0;
                exp_rd = 0;
            end
        end
    end

    task automatic run_frame(input int mode, input int dup_at, input bit fd_glitch, input bit exp_ovr);
        int fd0, b0, bc0, r0, c0, n;
        bit dup;
        fd0 = fd_cnt; b0 = beats; bc0 = busy_cyc; n = 0; dup = 0;
        @(posedge clk); #1;
        fft_done = 1;
        out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        c0 = cyc + 1;
        @(posedge clk); #1;
        fft_done = 0;
        while (fd_cnt == fd0 && n < 5000) begin
            out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            fft_done = (fd_glitch && frame_done) || (!dup && dup_at >= 0 && beats - b0 >= dup_at);
            dup = dup || fft_done;
            @(posedge clk); #1;
            n++;
        end
        fft_done = 0;
        r0 = rd_cnt;
        repeat (10) @(posedge clk);
        #1;
        chk("frame_beats", beats - b0, N);
        chk("frame_done_count", fd_cnt - fd0, 1);
        chk("overrun", overrun, exp_ovr);
        chk("busy_after", busy, 0);
        chk("no_reads_after", rd_cnt - r0, 0);
        if (mode == 0) begin
            chk("first_beat_latency", first_cyc - c0, 2);
            chk("done_after_last", fd_cyc - last_cyc, 1);
            chk("busy_cycles", busy_cyc - bc0, N + 2);
        end
    endtask

    initial begin
        int r0, fd0, b0, n;
        tbl[0] = '{0, -1, 1'b0, 1'b0};
        tbl[1] = '{1, -1, 1'b0, 1'b0};
        tbl[2] = '{0, 100, 1'b0, 1'b1};
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rd_en", rd_en, 0);
        chk("reset_overrun", overrun, 0);
        repeat (3) @(posedge clk);
        #1 reset_fft = 0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) run_frame(tbl[i].mode, tbl[i].dup_at, tbl[i].fd_glitch, tbl[i].exp_ovr);

        out_ready = 0; r0 = rd_cnt; fd0 = fd_cnt; b0 = beats;
        @(posedge clk); #1 fft_done = 1;
        @(posedge clk); #1 fft_done = 0;
        repeat (19) @(posedge clk);
        #1;
        chk("stall_reads", rd_cnt - r0, 2);
        chk("stall_head_valid", out_valid, 1);
        chk("stall_head_index", longint'(output_index), 0);
        out_ready = 1; n = 0;
        while (fd_cnt == fd0 && n < 2000) begin @(posedge clk); #1; n++; end
        chk("stall_frame_beats", beats - b0, N);

        b0 = beats; n = 0;
        @(posedge clk); #1 fft_done = 1;
        @(posedge clk); #1 fft_done = 0;
        while (beats - b0 < 300 && n < 2000) begin @(posedge clk); #1; n++; end
        chk("overrun_before_reset", overrun, 1);
        reset_fft = 1;
        #1;
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", longint'(rd_addr), 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_output_index", longint'(output_index), 0);
        chk("rst_bins", data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overrun", overrun, 0);
        @(posedge clk); #1 reset_fft = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("no_resume_busy", busy, 0);
        chk("no_resume_valid", out_valid, 0);
        run_frame(0, -1, 1'b0, 1'b0);
        run_frame(0, -1, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
